// File: rtl/seq_pkg.sv
// Shared encodings for the Y86-64 SEQ stage controller: stage codes, status codes,
// instruction codes and the per-icode class bundle.
package seq_pkg;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned ICODE_W = 4;
   localparam int unsigned STAT_W  = 3;

   localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] S_FETCH     = 3'd1;
   localparam logic [STATE_W-1:0] S_DECODE    = 3'd2;
   localparam logic [STATE_W-1:0] S_EXECUTE   = 3'd3;
   localparam logic [STATE_W-1:0] S_MEMORY    = 3'd4;
   localparam logic [STATE_W-1:0] S_WRITEBACK = 3'd5;
   localparam logic [STATE_W-1:0] S_PCUPDATE  = 3'd6;
   localparam logic [STATE_W-1:0] S_STOPPED   = 3'd7;

   localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
   localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
   localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
   localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

   localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
   localparam logic [ICODE_W-1:0] INOP    = 4'h1;
   localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
   localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
   localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
   localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
   localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
   localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
   localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
   localparam logic [ICODE_W-1:0] IRET    = 4'h9;
   localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
   localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

   typedef struct packed {
      logic is_mem;
      logic is_mem_write;
      logic writes_reg;
      logic sets_cc;
   } icode_class_t;
endpackage

// File: rtl/seq_icode_class.sv
// Combinational icode classifier: which instructions touch data memory, write it,
// write the register file, or update the condition codes.
module seq_icode_class
   import seq_pkg::*;
(
   input  logic [ICODE_W-1:0] icode,
   output icode_class_t       cls_c
);

   always_comb begin
      cls_c = '0;
      case (icode)
         IHALT, INOP, IJXX: cls_c = '0;
         IRRMOVQ, IIRMOVQ: cls_c.writes_reg = 1'b1;
         IRMMOVQ: begin
            cls_c.is_mem       = 1'b1;
            cls_c.is_mem_write = 1'b1;
         end
         IMRMOVQ: begin
            cls_c.is_mem     = 1'b1;
            cls_c.writes_reg = 1'b1;
         end
         IOPQ: begin
            cls_c.writes_reg = 1'b1;
            cls_c.sets_cc    = 1'b1;
         end
         // Stack ops write memory and update %rsp.
         ICALL, IPUSHQ: begin
            cls_c.is_mem       = 1'b1;
            cls_c.is_mem_write = 1'b1;
            cls_c.writes_reg   = 1'b1;
         end
         IRET, IPOPQ: begin
            cls_c.is_mem     = 1'b1;
            cls_c.writes_reg = 1'b1;
         end
         default: cls_c = '0;
      endcase
   end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: stage FSM, write strobes,
// memory handshakes, status/stop handling and saturating cycle/retire counters.
module seq_stage_controller
   import seq_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               single_step,
   input  logic [ICODE_W-1:0] icode,
   input  logic               instr_valid,
   input  logic               imem_error,
   input  logic               imem_ready,
   input  logic               dmem_error,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               cc_we,
   output logic               reg_we,
   output logic               dmem_we,
   output logic               pc_we,
   output logic [STAT_W-1:0]  stat,
   output logic               busy,
   output logic [STATE_W-1:0] stage,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [CNT_W-1:0]   instr_count
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [STAT_W-1:0]  stat_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               wait_expired_c;
   icode_class_t       cls_c;

   seq_icode_class u_icode_class (
      .icode (icode),
      .cls_c (cls_c)
   );

   assign stage          = state_q;
   assign wait_expired_c = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   // The write must land in the ready cycle and be vetoed by that cycle's error,
   // so it is qualified combinationally from the registered stage.
   assign dmem_we = rst_n && (state_q == S_MEMORY) && cls_c.is_mem_write &&
                    dmem_ready && !dmem_error;

   // Next-state, status and memory-wait counter.
   always_comb begin
      state_d = state_q;
      stat_d  = stat;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               if (imem_error) begin
                  stat_d  = STAT_ADR;
                  state_d = S_STOPPED;
               end else if (!instr_valid) begin
                  stat_d  = STAT_INS;
                  state_d = S_STOPPED;
               end else if (icode == IHALT) begin
                  stat_d  = STAT_HLT;
                  state_d = S_STOPPED;
               end else begin
                  state_d = S_DECODE;
               end
            end else if (wait_expired_c) begin
               stat_d  = STAT_ADR;
               state_d = S_STOPPED;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_DECODE:  state_d = S_EXECUTE;
         S_EXECUTE: state_d = S_MEMORY;
         S_MEMORY: begin
            if (!cls_c.is_mem) begin
               state_d = S_WRITEBACK;
            end else if (dmem_ready) begin
               if (dmem_error) begin
                  stat_d  = STAT_ADR;
                  state_d = S_STOPPED;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end else if (wait_expired_c) begin
               stat_d  = STAT_ADR;
               state_d = S_STOPPED;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WRITEBACK: state_d = S_PCUPDATE;
         S_PCUPDATE:  state_d = (single_step || !start) ? S_IDLE : S_FETCH;
         S_STOPPED:   state_d = S_STOPPED;
         default:     state_d = S_IDLE;
      endcase
      if (state_d != state_q) wait_d = '0;
   end

   // State, registered strobes decoded from the next stage, and counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         stat        <= STAT_AOK;
         wait_q      <= '0;
         imem_req    <= 1'b0;
         dmem_req    <= 1'b0;
         cc_we       <= 1'b0;
         reg_we      <= 1'b0;
         pc_we       <= 1'b0;
         busy        <= 1'b0;
         cycle_count <= '0;
         instr_count <= '0;
      end else begin
         state_q  <= state_d;
         stat     <= stat_d;
         wait_q   <= wait_d;
         imem_req <= (state_d == S_FETCH);
         dmem_req <= (state_d == S_MEMORY) && cls_c.is_mem;
         cc_we    <= (state_d == S_EXECUTE) && cls_c.sets_cc;
         reg_we   <= (state_d == S_WRITEBACK) && cls_c.writes_reg;
         pc_we    <= (state_d == S_PCUPDATE);
         busy     <= (state_d != S_IDLE) && (state_d != S_STOPPED);
         if ((state_q != S_IDLE) && (state_q != S_STOPPED) && (cycle_count != {CNT_W{1'b1}}))
            cycle_count <= cycle_count + CNT_W'(1);
         if ((state_d == S_PCUPDATE) && (instr_count != {CNT_W{1'b1}}))
            instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized self-checking bench: each instruction is expanded into its expected
// cycle-by-cycle trace, driven into the controller, and compared every cycle.
module tb_seq_stage_controller;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned MEM_TIMEOUT = 15;
   localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

   localparam int M_IDLE = 0;
   localparam int M_STOP = 1;
   localparam int M_UNK  = 2;
   localparam int M_RUN  = 3;

   typedef struct packed {
      logic       chk;
      logic       rst_n;
      logic       start;
      logic       single_step;
      logic [3:0] icode;
      logic       instr_valid;
      logic       imem_error;
      logic       imem_ready;
      logic       dmem_error;
      logic       dmem_ready;
      logic [2:0] stage;
      logic [2:0] stat;
      logic       busy;
      logic       imem_req;
      logic       dmem_req;
      logic       cc_we;
      logic       reg_we;
      logic       dmem_we;
      logic       pc_we;
   } rec_t;

   logic             clk = 1'b0;
   logic             rst_n, start, single_step, instr_valid;
   logic             imem_error, imem_ready, dmem_error, dmem_ready;
   logic [3:0]       icode;
   logic             imem_req, dmem_req, cc_we, reg_we, dmem_we, pc_we, busy;
   logic [2:0]       stat, stage;
   logic [CNT_W-1:0] cycle_count, instr_count;

   seq_stage_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .single_step (single_step),
      .icode       (icode),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .imem_ready  (imem_ready),
      .dmem_error  (dmem_error),
      .dmem_ready  (dmem_ready),
      .imem_req    (imem_req),
      .dmem_req    (dmem_req),
      .cc_we       (cc_we),
      .reg_we      (reg_we),
      .dmem_we     (dmem_we),
      .pc_we       (pc_we),
      .stat        (stat),
      .busy        (busy),
      .stage       (stage),
      .cycle_count (cycle_count),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc_n    = 0;
   int         m_mode   = M_UNK;
   logic [2:0] m_stat   = 3'd1;
   logic [3:0] cur_icode = 4'd1;
   int         m_cyc    = 0;
   int         m_instr  = 0;
   rec_t       exp_q[$];
   rec_t       e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc_n, act, req);
      end
   endtask

   // Single compare process: one expected record per clock cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cyc_n++;
         if (e.chk) begin
            if (e.pc_we && m_instr != int'(CNT_MAX)) m_instr++;
            check("stage",       32'(stage),       32'(e.stage));
            check("stat",        32'(stat),        32'(e.stat));
            check("busy",        32'(busy),        32'(e.busy));
            check("imem_req",    32'(imem_req),    32'(e.imem_req));
            check("dmem_req",    32'(dmem_req),    32'(e.dmem_req));
            check("cc_we",       32'(cc_we),       32'(e.cc_we));
            check("reg_we",      32'(reg_we),      32'(e.reg_we));
            check("dmem_we",     32'(dmem_we),     32'(e.dmem_we));
            check("pc_we",       32'(pc_we),       32'(e.pc_we));
            check("cycle_count", 32'(cycle_count), 32'(m_cyc));
            check("instr_count", 32'(instr_count), 32'(m_instr));
         end
         if (!e.rst_n) begin
            m_cyc   = 0;
            m_instr = 0;
         end else if (e.stage >= 3'd1 && e.stage <= 3'd6 && m_cyc != int'(CNT_MAX)) begin
            m_cyc++;
         end
      end
   end

   function automatic rec_t base(input logic [2:0] stg);
      rec_t r;
      r             = '0;
      r.chk         = 1'b1;
      r.rst_n       = 1'b1;
      r.start       = 1'($urandom);
      r.single_step = 1'($urandom);
      r.instr_valid = 1'($urandom);
      r.imem_error  = 1'($urandom);
      r.imem_ready  = 1'($urandom);
      r.dmem_error  = 1'($urandom);
      r.dmem_ready  = 1'($urandom);
      r.icode       = cur_icode;
      r.stage       = stg;
      r.stat        = m_stat;
      r.busy        = (stg != 3'd0) && (stg != 3'd7);
      return r;
   endfunction

   task automatic emit(input rec_t r);
      @(posedge clk);
      #1;
      rst_n       = r.rst_n;
      start       = r.start;
      single_step = r.single_step;
      icode       = r.icode;
      instr_valid = r.instr_valid;
      imem_error  = r.imem_error;
      imem_ready  = r.imem_ready;
      dmem_error  = r.dmem_error;
      dmem_ready  = r.dmem_ready;
      exp_q.push_back(r);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      rec_t r;
      for (int i = 0; i < n; i++) begin
         if (m_mode == M_STOP)     r = base(3'd7);
         else if (m_mode == M_RUN) begin r = base(3'd1); r.imem_req = 1'b1; end
         else                      begin r = base(3'd0); r.start = 1'b0; end
         r.chk   = (m_mode != M_UNK);
         r.rst_n = 1'b0;
         emit(r);
         m_mode = M_IDLE;
         m_stat = 3'd1;
      end
   endtask

   task automatic idle_cycles(input int n);
      rec_t r;
      for (int i = 0; i < n; i++) begin
         r = base(3'd0);
         r.start = 1'b0;
         emit(r);
      end
   endtask

   task automatic stopped_cycles(input int n);
      for (int i = 0; i < n; i++) emit(base(3'd7));
   endtask

   // Expand one instruction into its expected trace. pcu_mode: 0 single-step stop,
   // 1 continue, 2 stop by dropping start. lat = cycles from FETCH entry to pc_we.
   task automatic run_instr(input logic [3:0] ic, input int fw, input logic ierr,
                            input logic ival, input int mw, input logic derr,
                            input int pcu_mode, input logic rst_mem,
                            output int lat, output int dreq);
      rec_t r;
      logic is_mem, is_wr, wr_reg, rdy;
      cur_icode = ic;
      is_mem = ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
      is_wr  = ic inside {4'd4, 4'd8, 4'd10};
      wr_reg = ic inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
      lat  = 0;
      dreq = 0;
      if (m_mode == M_IDLE) begin
         r = base(3'd0);
         r.start = 1'b1;
         emit(r);
      end
      m_mode = M_RUN;
      for (int k = 0; ; k++) begin
         r = base(3'd1);
         r.imem_req = 1'b1;
         rdy = (k == fw);
         r.imem_ready = rdy;
         if (rdy) begin
            r.imem_error  = ierr;
            r.instr_valid = ival;
         end
         emit(r);
         lat++;
         if (rdy) break;
         if (k + 1 == int'(MEM_TIMEOUT)) begin m_stat = 3'd3; m_mode = M_STOP; return; end
      end
      if (ierr)            begin m_stat = 3'd3; m_mode = M_STOP; return; end
      else if (!ival)      begin m_stat = 3'd4; m_mode = M_STOP; return; end
      else if (ic == 4'd0) begin m_stat = 3'd2; m_mode = M_STOP; return; end
      emit(base(3'd2));
      r = base(3'd3);
      r.cc_we = (ic == 4'd6);
      emit(r);
      lat += 2;
      for (int k = 0; ; k++) begin
         r = base(3'd4);
         r.dmem_req = is_mem;
         rdy = is_mem && (k == mw);
         if (is_mem) begin
            r.dmem_ready = rdy;
            if (rdy) r.dmem_error = derr;
            r.dmem_we = rdy && is_wr && !derr;
            dreq++;
         end
         if (rst_mem) begin
            r.rst_n      = 1'b0;
            r.dmem_ready = 1'b1;
            r.dmem_error = 1'b0;
            r.dmem_we    = 1'b0;
            emit(r);
            m_mode = M_IDLE;
            m_stat = 3'd1;
            return;
         end
         emit(r);
         lat++;
         if (!is_mem) break;
         if (rdy) begin
            if (derr) begin m_stat = 3'd3; m_mode = M_STOP; return; end
            break;
         end
         if (k + 1 == int'(MEM_TIMEOUT)) begin m_stat = 3'd3; m_mode = M_STOP; return; end
      end
      r = base(3'd5);
      r.reg_we = wr_reg;
      emit(r);
      r = base(3'd6);
      r.pc_we = 1'b1;
      case (pcu_mode)
         0:       r.single_step = 1'b1;
         1:       begin r.start = 1'b1; r.single_step = 1'b0; end
         default: r.start = 1'b0;
      endcase
      emit(r);
      lat += 2;
      m_mode = (pcu_mode == 1) ? M_RUN : M_IDLE;
   endtask

   initial begin
      int lat, dq, fw, mw, pm;
      logic [3:0] ic;
      rst_n = 1'b0; start = 1'b0; single_step = 1'b0; icode = 4'd0;
      instr_valid = 1'b0; imem_error = 1'b0; imem_ready = 1'b0;
      dmem_error = 1'b0; dmem_ready = 1'b0;

      do_reset(2);
      idle_cycles(10);
      drain();
      check("idle_stage", 32'(stage), 32'd0);
      check("idle_stat", 32'(stat), 32'd1);
      check("idle_cycle_count", 32'(cycle_count), 32'd0);

      run_instr(4'd6, 0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, lat, dq);
      drain();
      check("opq_latency", 32'(lat), 32'd6);
      check("opq_dmem_req_cycles", 32'(dq), 32'd0);
      check("opq_instr_count", 32'(instr_count), 32'd1);

      run_instr(4'd4, 0, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, lat, dq);
      check("rmmovq_latency", 32'(lat), 32'd9);
      check("rmmovq_dmem_req_cycles", 32'(dq), 32'd4);

      do_reset(2);
      run_instr(4'd1, 0, 1'b0, 1'b1, 0, 1'b0, 1, 1'b0, lat, dq);
      run_instr(4'd0, 1, 1'b0, 1'b1, 0, 1'b0, 1, 1'b0, lat, dq);
      stopped_cycles(8);
      drain();
      check("halt_stat", 32'(stat), 32'd2);
      check("halt_stage", 32'(stage), 32'd7);
      check("halt_instr_count", 32'(instr_count), 32'd1);

      do_reset(2);
      run_instr(4'd3, 2, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, lat, dq);
      stopped_cycles(3);
      drain();
      check("adr_priority_stat", 32'(stat), 32'd3);

      do_reset(2);
      run_instr(4'd2, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, lat, dq);
      stopped_cycles(3);
      drain();
      check("ins_stat", 32'(stat), 32'd4);

      do_reset(2);
      run_instr(4'd5, 0, 1'b0, 1'b1, 2, 1'b1, 0, 1'b0, lat, dq);
      stopped_cycles(3);
      drain();
      check("dmem_error_stat", 32'(stat), 32'd3);

      do_reset(2);
      for (int i = 0; i < 3; i++)
         run_instr(4'($urandom_range(1, 11)), 0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0, lat, dq);
      drain();
      check("single_step_instr_count", 32'(instr_count), 32'd3);

      do_reset(2);
      run_instr(4'd5, 0, 1'b0, 1'b1, 100, 1'b0, 0, 1'b0, lat, dq);
      check("dmem_timeout_cycles", 32'(dq), 32'd15);
      stopped_cycles(2);
      drain();
      check("dmem_timeout_stat", 32'(stat), 32'd3);

      do_reset(2);
      run_instr(4'd1, 100, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, lat, dq);
      check("imem_timeout_cycles", 32'(lat), 32'd15);
      stopped_cycles(2);

      do_reset(2);
      run_instr(4'd4, 0, 1'b0, 1'b1, 2, 1'b0, 0, 1'b1, lat, dq);
      idle_cycles(3);
      drain();
      check("reset_in_memory_stage", 32'(stage), 32'd0);

      // Long uninterrupted run drives both counters into saturation.
      do_reset(1);
      for (int i = 0; i < 270; i++)
         run_instr(4'($urandom_range(1, 11)), 0, 1'b0, 1'b1, 0, 1'b0,
                   (i == 269) ? 0 : 1, 1'b0, lat, dq);
      drain();
      check("sat_cycle_count", 32'(cycle_count), 32'(CNT_MAX));
      check("sat_instr_count", 32'(instr_count), 32'(CNT_MAX));

      do_reset(1);
      for (int i = 0; i < 250; i++) begin
         if (m_mode == M_STOP) begin
            stopped_cycles($urandom_range(1, 3));
            do_reset($urandom_range(1, 2));
         end else begin
            if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            ic = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
            fw = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 4);
            pm = $urandom_range(0, 3);
            pm = (pm == 0) ? 0 : ((pm == 1) ? 2 : 1);
            run_instr(ic, fw, 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 24) != 0),
                      mw, 1'($urandom_range(0, 11) == 0), pm, 1'($urandom_range(0, 32) == 0),
                      lat, dq);
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
